stack_seq_ctrl: RTL

- Sequencer for stack-based control transfers other than CALL: RET, RTI and hardware interrupt entry.
- Sits beside the fetch/decode boundary. It injects stack micro-op instruction words into decode and stalls fetch.
- Collects popped words returned from the memory stage, then redirects the PC for one cycle.

---
 rtl/stack_seq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/stack_seq_ctrl.sv
// Stack sequencer for RET, RTI and interrupt entry: injects stack micro-ops into
// decode, stalls fetch, collects popped PC/flags words and issues a one-cycle redirect.
module stack_seq_ctrl #(
    parameter logic [15:0] PUSH_PC_LOW_OP  = 16'h6008,
    parameter logic [15:0] PUSH_PC_HIGH_OP = 16'h6009,
    parameter logic [15:0] POP_PC_LOW_OP   = 16'h600A,
    parameter logic [15:0] POP_PC_HIGH_OP  = 16'h600B,
    parameter logic [15:0] PUSH_FLAGS_OP   = 16'h600C,
    parameter logic [15:0] POP_FLAGS_OP    = 16'h600D,
    parameter logic [31:0] INT_VECTOR      = 32'h0000_0020,
    parameter int unsigned DRAIN_CYCLES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ret,
    input  logic        rti,
    input  logic        intr,
    input  logic        pop_valid,
    input  logic [15:0] pop_data,
    output logic [15:0] out,
    output logic        stall,
    output logic        change_pc,
    output logic [31:0] new_pc,
    output logic        restore_flags,
    output logic [2:0]  flags_value,
    output logic        int_ack
);

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned DRAIN_W = 3;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        POP_FLAGS  = 4'd1,
        POP_HIGH   = 4'd2,
        POP_LOW    = 4'd3,
        WAIT_POP   = 4'd4,
        PUSH_LOW   = 4'd5,
        PUSH_HIGH  = 4'd6,
        PUSH_FLAGS = 4'd7,
        DRAIN      = 4'd8,
        REDIRECT   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        SEQ_RET = 2'd0,
        SEQ_RTI = 2'd1,
        SEQ_INT = 2'd2
    } seq_t;

    state_t             state_q, state_d;
    seq_t               seq_q;
    logic               pend_int_q;
    logic [CNT_W-1:0]   pop_cnt_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic [15:0]        hi_q, lo_q;
    logic [2:0]         flags_q;
    logic [31:0]        new_pc_q;

    logic               accept_rti, accept_ret, accept_int;
    logic               collecting, pop_take, pops_done;
    logic [CNT_W-1:0]   pop_total, pop_idx;

    // Trigger arbitration and pop bookkeeping; pop_idx maps a pop to flags(0)/hi(1)/lo(2)
    always_comb begin
        accept_rti = (state_q == IDLE) && rti;
        accept_ret = (state_q == IDLE) && !rti && ret;
        accept_int = (state_q == IDLE) && !rti && !ret && pend_int_q;
        collecting = (state_q == POP_FLAGS) || (state_q == POP_HIGH) ||
                     (state_q == POP_LOW)   || (state_q == WAIT_POP);
        pop_total  = (seq_q == SEQ_RTI) ? CNT_W'(3) : CNT_W'(2);
        pop_idx    = (seq_q == SEQ_RTI) ? pop_cnt_q : CNT_W'(pop_cnt_q + CNT_W'(1));
        pop_take   = collecting && pop_valid && (pop_cnt_q != pop_total);
        pops_done  = (pop_cnt_q == pop_total) ||
                     (pop_take && (pop_cnt_q == CNT_W'(pop_total - CNT_W'(1))));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_rti)      state_d = POP_FLAGS;
                else if (accept_ret) state_d = POP_HIGH;
                else if (accept_int) state_d = PUSH_LOW;
            end
            POP_FLAGS:  state_d = POP_HIGH;
            POP_HIGH:   state_d = POP_LOW;
            POP_LOW:    state_d = WAIT_POP;
            WAIT_POP:   if (pops_done) state_d = REDIRECT;
            PUSH_LOW:   state_d = PUSH_HIGH;
            PUSH_HIGH:  state_d = PUSH_FLAGS;
            PUSH_FLAGS: state_d = DRAIN;
            DRAIN:      if (drain_cnt_q <= DRAIN_W'(1)) state_d = REDIRECT;
            REDIRECT:   state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decode from the state register; restore_flags follows the first RTI pop
    always_comb begin
        out           = 16'h0000;
        stall         = (state_q != IDLE);
        change_pc     = 1'b0;
        int_ack       = 1'b0;
        new_pc        = new_pc_q;
        restore_flags = pop_take && (pop_idx == CNT_W'(0));
        flags_value   = restore_flags ? pop_data[2:0] : flags_q;
        case (state_q)
            POP_FLAGS:  out = POP_FLAGS_OP;
            POP_HIGH:   out = POP_PC_HIGH_OP;
            POP_LOW:    out = POP_PC_LOW_OP;
            PUSH_LOW:   out = PUSH_PC_LOW_OP;
            PUSH_HIGH:  out = PUSH_PC_HIGH_OP;
            PUSH_FLAGS: out = PUSH_FLAGS_OP;
            REDIRECT: begin
                change_pc = 1'b1;
                int_ack   = (seq_q == SEQ_INT);
                new_pc    = (seq_q == SEQ_INT) ? INT_VECTOR : {hi_q, lo_q};
            end
            default: out = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q       <= SEQ_RET;
            pend_int_q  <= 1'b0;
            pop_cnt_q   <= '0;
            drain_cnt_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            flags_q     <= '0;
            new_pc_q    <= '0;
        end else begin
            if (accept_rti)      seq_q <= SEQ_RTI;
            else if (accept_ret) seq_q <= SEQ_RET;
            else if (accept_int) seq_q <= SEQ_INT;

            if (accept_rti || accept_ret || accept_int) pop_cnt_q <= '0;
            else if (pop_take)                          pop_cnt_q <= CNT_W'(pop_cnt_q + CNT_W'(1));

            if (accept_int) pend_int_q <= 1'b0;
            else if (intr)  pend_int_q <= 1'b1;

            if (pop_take) begin
                case (pop_idx)
                    CNT_W'(0): flags_q <= pop_data[2:0];
                    CNT_W'(1): hi_q    <= pop_data;
                    default:   lo_q    <= pop_data;
                endcase
            end

            if (state_q == PUSH_FLAGS)  drain_cnt_q <= DRAIN_W'(DRAIN_CYCLES);
            else if (state_q == DRAIN)  drain_cnt_q <= DRAIN_W'(drain_cnt_q - DRAIN_W'(1));

            if (state_q == REDIRECT) new_pc_q <= new_pc;
        end
    end

endmodule
